// File: rtl/pontuacao_pkg.sv
// Shared definitions for the scoring datapath (controle_pontuacao and
// divisor_sequencial).
//   estado_t      : controller states, also exported on the debug port
//   MAX_SCORE     : score saturation ceiling
//   PENALTY_UNIT  : points subtracted per error in a round
//   ROUNDS_LOW/HIGH : rounds per game for nivel 0 / nivel 1
//   DIV_CYCLES    : divider latency, one quotient bit per cycle
//   *_W           : widths of score, round counter, error counter, divider
//   soma_rodadas  : N*(N+1)/2, the gain divisor for an N-round game
package pontuacao_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    JOGANDO    = 3'd1,
    DIVIDINDO  = 3'd2,
    ACUMULANDO = 3'd3,
    FIM        = 3'd4
  } estado_t;

  localparam int MAX_SCORE    = 100;
  localparam int PENALTY_UNIT = 2;
  localparam int ROUNDS_LOW   = 8;
  localparam int ROUNDS_HIGH  = 16;
  localparam int DIV_CYCLES   = 11;

  localparam int SCORE_W = 7;
  localparam int ROUND_W = 5;
  localparam int ERR_W   = 4;
  localparam int NUM_W   = 11;
  localparam int DIV_W   = 8;
  localparam int QUO_W   = 8;

  // Sum 1+2+...+n; 36 for 8 rounds, 136 for 16 rounds.
  function automatic logic [DIV_W-1:0] soma_rodadas(input int n);
    return DIV_W'((n * (n + 1)) / 2);
  endfunction

endpackage

// File: rtl/divisor_sequencial.sv
// Restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   start          : load numerador/divisor and begin (restarts any division
//                    already in flight)
//   numerador[10:0]: dividend
//   divisor[7:0]   : divisor, must be non-zero
//   done           : one-cycle pulse, exactly DIV_CYCLES cycles after start
//   quociente[7:0] : quotient, valid from done until the next start
// Handshake: start is a single-cycle request sampled at a rising edge; done
// rises DIV_CYCLES edges later for one cycle; there is no back-pressure.
import pontuacao_pkg::*;

module divisor_sequencial (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerador,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [QUO_W-1:0] quociente
);

  logic [DIV_W-1:0] resto_q;
  logic [NUM_W-1:0] quo_q;
  logic [DIV_W-1:0] dvs_q;
  logic [3:0]       cnt_q;
  logic             busy_q;

  logic [DIV_W-1:0] trial_lo;
  logic             ge;
  logic [DIV_W-1:0] diff;

  // The shifted partial remainder is 9 bits: {resto_q, next numerator bit}.
  // Its top bit is resto_q[7]; if set the trial is >= 256 > divisor, so the
  // subtraction always happens and the 8-bit wrap-around result is exact
  // (the true remainder is always below the divisor).
  always_comb begin
    trial_lo = {resto_q[DIV_W-2:0], quo_q[NUM_W-1]};
    ge       = resto_q[DIV_W-1] | (trial_lo >= dvs_q);
    diff     = trial_lo - dvs_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resto_q <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        resto_q <= '0;
        quo_q   <= numerador;
        dvs_q   <= divisor;
        cnt_q   <= 4'(DIV_CYCLES);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        resto_q <= ge ? diff : trial_lo;
        quo_q   <= {quo_q[NUM_W-2:0], ge};
        cnt_q   <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quociente = quo_q[QUO_W-1:0];

endmodule

// File: rtl/controle_pontuacao.sv
// Scoring sequencer between the game FSM and the score display.
// Tracks completed rounds and per-round errors; at each round end divides
// (rodada+1)*100 by N*(N+1)/2 to get the round base, subtracts the error
// penalty, accumulates into pontos with saturation at MAX_SCORE, and flags
// the last round (fim_jogo) and a clean last round (perfeito).
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   iniciar        : pulse, start a new game (any state), latches nivel
//   nivel          : 0 = 8 rounds, 1 = 16 rounds
//   erro           : pulse, one error in the current round
//   fim_rodada     : pulse, current round finished
//   pontos[6:0]    : accumulated score 0..100
//   rodada[4:0]    : completed rounds
//   erros[3:0]     : errors in the current round, saturating at 15
//   ocupado        : scoring in progress
//   pontos_validos : one-cycle pulse when pontos is updated
//   fim_jogo       : level, last round scored
//   perfeito       : level, last round scored with zero errors
//   estado         : debug view of the controller state
// Build option: define PONTUACAO_BONUS_PERFEITO_EN to force pontos to
// MAX_SCORE when the last round commits with no errors.
// Timing: fim_rodada sampled at edge E0 starts the divider at that same edge;
// the quotient is ready after E11, ACUMULANDO runs E12..E13 and the commit
// lands on E13. ocupado covers E1..E13 (12 cycles).
import pontuacao_pkg::*;

module controle_pontuacao (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               nivel,
  input  logic               erro,
  input  logic               fim_rodada,
  output logic [SCORE_W-1:0] pontos,
  output logic [ROUND_W-1:0] rodada,
  output logic [ERR_W-1:0]   erros,
  output logic               ocupado,
  output logic               pontos_validos,
  output logic               fim_jogo,
  output logic               perfeito,
  output estado_t            estado
);

  localparam logic [SCORE_W:0]   MAX_SUM    = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAX_PONTOS = SCORE_W'(MAX_SCORE);

  estado_t state_q, state_d;

  logic               nivel_q;
  logic [ERR_W-1:0]   err_lat;
  logic [ERR_W-1:0]   erros_inc;
  logic               conta_erro;

  logic               div_start;
  logic               div_done;
  logic [NUM_W-1:0]   numerador;
  logic [DIV_W-1:0]   divisor;
  logic [QUO_W-1:0]   base;

  logic [ROUND_W-1:0] n_rodadas;
  logic               ultima;
  logic [7:0]         penalty;
  logic [7:0]         gain;
  logic [SCORE_W+1:0] soma;
  logic [SCORE_W-1:0] pontos_novo;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (!reset) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    if (iniciar) begin
      state_d = JOGANDO;
    end else begin
      unique case (state_q)
        OCIOSO:     state_d = OCIOSO;
        JOGANDO: begin
          if (fim_rodada) begin
            state_d   = DIVIDINDO;
            div_start = 1'b1;
          end
        end
        DIVIDINDO:  if (div_done) state_d = ACUMULANDO;
        ACUMULANDO: state_d = ultima ? FIM : JOGANDO;
        FIM:        state_d = FIM;
        default:    state_d = OCIOSO;
      endcase
    end
  end

  assign estado = state_q;

  // ------------------------------------------------------- arithmetic
  always_comb begin
    erros_inc = (erros == {ERR_W{1'b1}}) ? erros : erros + 1'b1;
    // Errors keep counting while a round is being scored; they belong to
    // the next round. FIM and OCIOSO ignore them.
    conta_erro = erro && ((state_q == JOGANDO) || (state_q == DIVIDINDO) ||
                          (state_q == ACUMULANDO));

    n_rodadas = nivel_q ? ROUND_W'(ROUNDS_HIGH) : ROUND_W'(ROUNDS_LOW);
    divisor   = nivel_q ? soma_rodadas(ROUNDS_HIGH) : soma_rodadas(ROUNDS_LOW);
    numerador = (NUM_W'(rodada) + 11'd1) * 11'd100;
    ultima    = (rodada + 1'b1) == n_rodadas;

    penalty = 8'(err_lat) * 8'(PENALTY_UNIT);
    gain    = (base > penalty) ? (base - penalty) : 8'd0;
    soma    = (SCORE_W+2)'(pontos) + (SCORE_W+2)'(gain);
    pontos_novo = (soma > (SCORE_W+2)'(MAX_SUM)) ? MAX_PONTOS : soma[SCORE_W-1:0];
`ifdef PONTUACAO_BONUS_PERFEITO_EN
    if (ultima && (err_lat == '0)) pontos_novo = MAX_PONTOS;
`else
    pontos_novo = pontos_novo;
`endif
  end

  divisor_sequencial u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .numerador (numerador),
    .divisor   (divisor),
    .done      (div_done),
    .quociente (base)
  );

  // -------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (!reset) begin
      pontos         <= '0;
      rodada         <= '0;
      erros          <= '0;
      err_lat        <= '0;
      nivel_q        <= 1'b0;
      ocupado        <= 1'b0;
      pontos_validos <= 1'b0;
      fim_jogo       <= 1'b0;
      perfeito       <= 1'b0;
    end else if (iniciar) begin
      pontos         <= '0;
      rodada         <= '0;
      erros          <= '0;
      err_lat        <= '0;
      nivel_q        <= nivel;
      ocupado        <= 1'b0;
      pontos_validos <= 1'b0;
      fim_jogo       <= 1'b0;
      perfeito       <= 1'b0;
    end else begin
      pontos_validos <= 1'b0;

      // An erro in the same cycle as fim_rodada belongs to the ending round.
      if (state_q == JOGANDO && fim_rodada) begin
        err_lat <= erro ? erros_inc : erros;
        erros   <= '0;
      end else if (conta_erro) begin
        erros <= erros_inc;
      end

      if (state_q == DIVIDINDO) ocupado <= 1'b1;

      if (state_q == ACUMULANDO) begin
        pontos         <= pontos_novo;
        rodada         <= rodada + 1'b1;
        pontos_validos <= 1'b1;
        ocupado        <= 1'b0;
        if (ultima) begin
          fim_jogo <= 1'b1;
          perfeito <= (err_lat == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_controle_pontuacao.sv
module tb_controle_pontuacao;
  import pontuacao_pkg::*;

  // ---------------------------------------------------- clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       nivel = 1'b0;
  logic       erro = 1'b0;
  logic       fim_rodada = 1'b0;
  logic [6:0] pontos;
  logic [4:0] rodada;
  logic [3:0] erros;
  logic       ocupado;
  logic       pontos_validos;
  logic       fim_jogo;
  logic       perfeito;
  estado_t    estado;

  always #5 clock = ~clock;

  controle_pontuacao dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .nivel          (nivel),
    .erro           (erro),
    .fim_rodada     (fim_rodada),
    .pontos         (pontos),
    .rodada         (rodada),
    .erros          (erros),
    .ocupado        (ocupado),
    .pontos_validos (pontos_validos),
    .fim_jogo       (fim_jogo),
    .perfeito       (perfeito),
    .estado         (estado)
  );

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------------------------------------------- scoreboard
  int n_chk  = 0;
  int n_pass = 0;
  logic [6:0] exp_q[$];

`ifdef PONTUACAO_BONUS_PERFEITO_EN
  localparam int CLEAN8  = 100;
  localparam int CLEAN16 = 100;
`else
  localparam int CLEAN8  = 96;
  localparam int CLEAN16 = 92;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: game rules in plain arithmetic.
  int m_pontos, m_rodada, m_err, m_n, m_fim, m_perf;

  task automatic model_new_game(input int nv);
    m_pontos = 0; m_rodada = 0; m_err = 0; m_fim = 0; m_perf = 0;
    m_n = nv ? 16 : 8;
  endtask

  task automatic model_round(input int same_err, input int busy_err);
    int e, base, pen, gain, p;
    e = m_err + same_err;
    if (e > 15) e = 15;
    base = ((m_rodada + 1) * 100) / ((m_n * (m_n + 1)) / 2);
    pen  = e * 2;
    gain = (base > pen) ? base - pen : 0;
    p    = m_pontos + gain;
    if (p > 100) p = 100;
    if (m_rodada + 1 == m_n) begin
      m_fim  = 1;
      m_perf = (e == 0);
`ifdef PONTUACAO_BONUS_PERFEITO_EN
      if (e == 0) p = 100;
`endif
    end
    m_pontos = p;
    m_rodada = m_rodada + 1;
    m_err    = (busy_err > 15) ? 15 : busy_err;
    exp_q.push_back(7'(p));
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic start_game(input int nv);
    @(negedge clock);
    iniciar = 1'b1;
    nivel   = nv[0];
    @(negedge clock);
    iniciar = 1'b0;
    model_new_game(nv);
    chk("start_pontos", int'(pontos), 0);
    chk("start_rodada", int'(rodada), 0);
    chk("start_estado", int'(estado), int'(JOGANDO));
    chk("start_fim_jogo", int'(fim_jogo), 0);
  endtask

  task automatic pulse_erros(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      erro = 1'b1;
      @(negedge clock);
      erro = 1'b0;
    end
    m_err = m_err + n;
    if (m_err > 15) m_err = 15;
    chk("erros_count", int'(erros), m_err);
  endtask

  // Count pontos_validos pulses over the next n cycles.
  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pontos_validos) cnt++;
    end
  endtask

  // Ends a round: optional erro in the same cycle as fim_rodada, erro
  // pulses while scoring, and an optional repeated fim_rodada while busy.
  task automatic end_round(input int same_err, input int busy_err, input bit refire);
    int k, busy_cnt, extra;
    logic [6:0] p_exp;
    model_round(same_err, busy_err);
    @(negedge clock);
    fim_rodada = 1'b1;
    erro       = same_err[0];
    @(negedge clock);
    fim_rodada = 1'b0;
    erro       = 1'b0;
    busy_cnt   = 0;
    for (k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      if (pontos_validos) break;
      if (ocupado) busy_cnt++;
      erro       = (k >= 1 && k <= busy_err);
      fim_rodada = refire && (k == 3);
    end
    erro       = 1'b0;
    fim_rodada = 1'b0;
    p_exp = exp_q.pop_front();
    chk("commit_latency", k, 13);
    chk("ocupado_cycles", busy_cnt, 12);
    chk("commit_pontos", int'(pontos), int'(p_exp));
    chk("commit_rodada", int'(rodada), m_rodada);
    chk("commit_ocupado", int'(ocupado), 0);
    chk("commit_erros", int'(erros), m_err);
    chk("commit_fim_jogo", int'(fim_jogo), m_fim);
    chk("commit_perfeito", int'(perfeito), m_perf);
    @(negedge clock);
    chk("valid_one_cycle", int'(pontos_validos), 0);
    if (refire) begin
      count_valid(16, extra);
      chk("refire_ignored", extra, 0);
    end
  endtask

  task automatic play_rounds(input int count, input bit rnd);
    int ne, same, busy;
    bit refire;
    for (int r = 0; r < count; r++) begin
      ne = 0; same = 0; busy = 0; refire = 0;
      if (rnd) begin
        ne     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 2);
        same   = $urandom_range(0, 1);
        busy   = $urandom_range(0, 4);
        refire = ($urandom_range(0, 3) == 0);
        nivel  = 1'($urandom_range(0, 1));  // mid-game nivel noise
      end
      if (ne > 0) pulse_erros(ne);
      end_round(same, busy, refire);
    end
  endtask

  // ---------------------------------------------------- main sequence
  initial begin
    int seq8[8];
    int cnt;
    logic [6:0] p_hold;
    seq8 = '{2, 7, 15, 26, 39, 55, 74, CLEAN8};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pontos", int'(pontos), 0);
    chk("rst_rodada", int'(rodada), 0);
    chk("rst_erros", int'(erros), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_valid", int'(pontos_validos), 0);
    chk("rst_fim_jogo", int'(fim_jogo), 0);
    chk("rst_perfeito", int'(perfeito), 0);
    chk("rst_estado", int'(estado), int'(OCIOSO));
    reset = 1'b1;

    // fim_rodada in OCIOSO is ignored
    @(negedge clock);
    fim_rodada = 1'b1;
    @(negedge clock);
    fim_rodada = 1'b0;
    count_valid(16, cnt);
    chk("ocioso_ignore_valid", cnt, 0);
    chk("ocioso_estado", int'(estado), int'(OCIOSO));

    // Full clean nivel-0 game with the known score sequence
    start_game(0);
    for (int r = 0; r < 8; r++) begin
      end_round(0, 0, 0);
      chk("clean8_seq", int'(pontos), seq8[r]);
    end
    chk("clean8_fim_jogo", int'(fim_jogo), 1);
    chk("clean8_perfeito", int'(perfeito), 1);
    chk("clean8_estado", int'(estado), int'(FIM));

    // FIM holds: erro and fim_rodada ignored
    p_hold = pontos;
    @(negedge clock);
    erro = 1'b1;
    fim_rodada = 1'b1;
    @(negedge clock);
    erro = 1'b0;
    fim_rodada = 1'b0;
    count_valid(16, cnt);
    chk("fim_ignore_valid", cnt, 0);
    chk("fim_hold_pontos", int'(pontos), int'(p_hold));
    chk("fim_hold_erros", int'(erros), 0);
    chk("fim_hold_estado", int'(estado), int'(FIM));

    // Penalty, error saturation, concurrency
    start_game(0);
    play_rounds(3, 0);
    chk("pen_pre", int'(pontos), 15);
    pulse_erros(3);
    end_round(0, 0, 0);
    chk("pen_round4", int'(pontos), 20);
    pulse_erros(20);
    chk("pen_sat_erros", int'(erros), 15);
    end_round(0, 0, 0);
    chk("pen_zero_gain", int'(pontos), 20);
    end_round(1, 3, 1);   // same-cycle erro, erros while busy, refire
    chk("conc_round6", int'(pontos), 34);
    end_round(0, 0, 0);   // the 3 busy errors score here
    chk("conc_round7", int'(pontos), 47);
    end_round(0, 0, 0);
    chk("conc_fim", int'(fim_jogo), 1);

    // Mid-game reset
    start_game(1);
    pulse_erros(2);
    end_round(0, 0, 0);
    pulse_erros(1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_rst_pontos", int'(pontos), 0);
    chk("mid_rst_rodada", int'(rodada), 0);
    chk("mid_rst_erros", int'(erros), 0);
    chk("mid_rst_ocupado", int'(ocupado), 0);
    chk("mid_rst_fim_jogo", int'(fim_jogo), 0);
    chk("mid_rst_estado", int'(estado), int'(OCIOSO));
    reset = 1'b1;

    // Abort during DIVIDINDO, new game latches nivel=1
    start_game(0);
    end_round(0, 0, 0);
    @(negedge clock);
    fim_rodada = 1'b1;
    @(negedge clock);
    fim_rodada = 1'b0;
    repeat (3) @(negedge clock);
    iniciar = 1'b1;
    nivel   = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    nivel   = 1'b0;
    model_new_game(1);
    count_valid(20, cnt);
    chk("abort_no_valid", cnt, 0);
    chk("abort_pontos", int'(pontos), 0);
    chk("abort_rodada", int'(rodada), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_estado", int'(estado), int'(JOGANDO));
    end_round(0, 0, 0);
    chk("n16_round1", int'(pontos), 0);
    play_rounds(14, 0);
    chk("n16_not_done", int'(fim_jogo), 0);
    end_round(0, 0, 0);
    chk("n16_final", int'(pontos), CLEAN16);
    chk("n16_fim_jogo", int'(fim_jogo), 1);
    chk("n16_perfeito", int'(perfeito), 1);

    // Randomized games against the model
    for (int g = 0; g < 4; g++) begin
      start_game(int'($urandom_range(0, 1)));
      play_rounds(m_n, 1);
      chk("rand_fim_jogo", int'(fim_jogo), 1);
      chk("rand_estado", int'(estado), int'(FIM));
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
